// File: rtl/cache_mem_arbiter_if.sv
// Bundle of the icache, dcache and physical-memory handshakes around the arbiter.
// The master modport is the arbiter's view; slave is the view of the caches and memory.
interface cache_mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LINE_WIDTH = 128
);
  // icache miss path
  logic                  i_pmem_read;
  logic [ADDR_WIDTH-1:0] i_pmem_address;
  logic [LINE_WIDTH-1:0] i_pmem_rdata;
  logic                  i_pmem_resp;

  // dcache miss / writeback path
  logic                  d_pmem_read;
  logic                  d_pmem_write;
  logic [ADDR_WIDTH-1:0] d_pmem_address;
  logic [LINE_WIDTH-1:0] d_pmem_wdata;
  logic [LINE_WIDTH-1:0] d_pmem_rdata;
  logic                  d_pmem_resp;

  // physical memory port
  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;

  modport master (
    input  i_pmem_read, i_pmem_address,
    input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    input  pmem_rdata, pmem_resp,
    output i_pmem_rdata, i_pmem_resp,
    output d_pmem_rdata, d_pmem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport slave (
    output i_pmem_read, i_pmem_address,
    output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    output pmem_rdata, pmem_resp,
    input  i_pmem_rdata, i_pmem_resp,
    input  d_pmem_rdata, d_pmem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Shares one physical-memory port between the icache and dcache miss paths,
// one line transfer at a time, alternating grants when both sides miss together.
module cache_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LINE_WIDTH = 128
) (
  input  logic                clk,
  input  logic                reset,
  cache_mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  // Transfer latched at grant time; held stable for the whole memory access.
  typedef struct packed {
    logic                  rd;
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LINE_WIDTH-1:0] wdata;
  } xfer_t;

  state_t state_q, state_d;
  grant_t last_q, last_d;
  xfer_t  xfer_q, xfer_d;

  logic i_req;
  logic d_req;
  logic grant_i;

  assign i_req = bus.i_pmem_read;
  assign d_req = bus.d_pmem_read | bus.d_pmem_write;

  // On contention the side that was not served last wins.
  assign grant_i = i_req & (~d_req | (last_q == GRANT_D));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= GRANT_I;
      xfer_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      xfer_q  <= xfer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    xfer_d  = xfer_q;

    unique case (state_q)
      IDLE: begin
        xfer_d.rd = 1'b0;
        xfer_d.wr = 1'b0;
        if (grant_i) begin
          state_d     = SERVE_I;
          xfer_d.rd   = 1'b1;
          xfer_d.wr   = 1'b0;
          xfer_d.addr = bus.i_pmem_address;
        end else if (d_req) begin
          // A dcache asserting both strobes is treated as a writeback.
          state_d      = SERVE_D;
          xfer_d.rd    = ~bus.d_pmem_write;
          xfer_d.wr    = bus.d_pmem_write;
          xfer_d.addr  = bus.d_pmem_address;
          xfer_d.wdata = bus.d_pmem_wdata;
        end
      end

      SERVE_I, SERVE_D: begin
        if (bus.pmem_resp) begin
          state_d   = IDLE;
          last_d    = (state_q == SERVE_I) ? GRANT_I : GRANT_D;
          xfer_d.rd = 1'b0;
          xfer_d.wr = 1'b0;
        end
      end

      default: begin
        state_d   = IDLE;
        xfer_d.rd = 1'b0;
        xfer_d.wr = 1'b0;
      end
    endcase
  end

  assign bus.pmem_read    = xfer_q.rd;
  assign bus.pmem_write   = xfer_q.wr;
  assign bus.pmem_address = xfer_q.addr;
  assign bus.pmem_wdata   = xfer_q.wdata;

  // Memory completion is forwarded to the owner with no added cycle.
  assign bus.i_pmem_resp  = (state_q == SERVE_I) & bus.pmem_resp;
  assign bus.d_pmem_resp  = (state_q == SERVE_D) & bus.pmem_resp;
  assign bus.i_pmem_rdata = bus.pmem_rdata;
  assign bus.d_pmem_rdata = bus.pmem_rdata;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: vector table, directed corner
// sequences and a randomized run against a transaction-level model.
module tb_cache_mem_arbiter;
  localparam int unsigned AW = 16;
  localparam int unsigned LW = 128;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  cache_mem_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

  cache_mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          i_rd;
    logic          d_rd;
    logic          d_wr;
    logic          exp_rd;
    logic          exp_wr;
    logic [AW-1:0] exp_addr;
    logic          exp_ir;
    logic          exp_dr;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_pmem_read    = 1'b0;
    bus.i_pmem_address = '0;
    bus.d_pmem_read    = 1'b0;
    bus.d_pmem_write   = 1'b0;
    bus.d_pmem_address = '0;
    bus.d_pmem_wdata   = '0;
    bus.pmem_resp      = 1'b0;
    bus.pmem_rdata     = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Lone transfer: memory answers lat cycles after the first strobe cycle.
  task automatic serve_one(input string tag, input logic [AW-1:0] ea, input logic ewr,
                           input logic [LW-1:0] ewd, input int lat, input logic own_i);
    int hi, ip, dp;
    logic str;
    logic [LW-1:0] pat;
    hi = 0; ip = 0; dp = 0;
    pat = {16{8'hA5}};
    for (int k = 0; k < lat + 8; k++) begin
      tick();
      if (ip > 0) bus.i_pmem_read = 1'b0;
      if (dp > 0) begin bus.d_pmem_read = 1'b0; bus.d_pmem_write = 1'b0; end
      str = bus.pmem_read | bus.pmem_write;
      if (str) hi++;
      if (hi == 2) begin
        bus.i_pmem_address = 16'h5550;
        bus.d_pmem_address = 16'h5550;
        bus.d_pmem_wdata   = ~ewd;
      end
      bus.pmem_resp  = str && (hi == lat + 1);
      bus.pmem_rdata = pat;
      @(negedge clk);
      if (str) begin
        chk({tag, "_addr"}, LW'(bus.pmem_address), LW'(ea));
        chk({tag, "_rd"}, LW'(bus.pmem_read), LW'(!ewr));
        chk({tag, "_wr"}, LW'(bus.pmem_write), LW'(ewr));
        if (ewr) chk({tag, "_wdata"}, bus.pmem_wdata, ewd);
      end
      if (bus.i_pmem_resp) begin ip++; chk({tag, "_irdata"}, bus.i_pmem_rdata, pat); end
      if (bus.d_pmem_resp) begin dp++; chk({tag, "_drdata"}, bus.d_pmem_rdata, pat); end
    end
    chk({tag, "_strobe_cycles"}, LW'(hi), LW'(lat + 1));
    chk({tag, "_iresp_count"}, LW'(ip), LW'(own_i ? 1 : 0));
    chk({tag, "_dresp_count"}, LW'(dp), LW'(own_i ? 0 : 1));
  endtask

  // Both caches miss in the same cycle; report grant order and idle gap.
  task automatic contend(output logic [AW-1:0] first_a, output logic [AW-1:0] second_a,
                         output int gap);
    int ng, hi, run;
    logic prev, str, i_got, d_got;
    bus.i_pmem_read = 1'b1; bus.i_pmem_address = 16'h1110;
    bus.d_pmem_read = 1'b1; bus.d_pmem_write = 1'b0; bus.d_pmem_address = 16'h2220;
    bus.pmem_resp = 1'b0;
    ng = 0; hi = 0; run = 0; gap = -1; prev = 1'b0; i_got = 1'b0; d_got = 1'b0;
    first_a = '0; second_a = '0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (i_got) bus.i_pmem_read = 1'b0;
      if (d_got) bus.d_pmem_read = 1'b0;
      i_got = 1'b0; d_got = 1'b0;
      str = bus.pmem_read | bus.pmem_write;
      hi = str ? hi + 1 : 0;
      bus.pmem_resp = str && (hi == 2);
      @(negedge clk);
      if (str && !prev) begin
        if (ng == 0) first_a = bus.pmem_address;
        else if (ng == 1) begin second_a = bus.pmem_address; gap = run; end
        ng++;
      end
      run  = str ? 0 : run + 1;
      prev = str;
      if (bus.i_pmem_resp) i_got = 1'b1;
      if (bus.d_pmem_resp) d_got = 1'b1;
    end
    chk("contend_grants", LW'(ng), LW'(2));
  endtask

  // Random caches and memory checked against a transaction-level model.
  task automatic random_phase(input int ncyc);
    bit m_busy, i_done, d_done, ireq, dreq;
    int m_owner, m_last, mem_cnt, i_wait, d_wait, max_wait, op;
    logic [AW-1:0] m_addr;
    logic          m_wr;
    logic [LW-1:0] m_wdata, rd_pat;
    m_busy = 0; m_owner = 0; m_last = 1; mem_cnt = -1;
    i_done = 0; d_done = 0; i_wait = 0; d_wait = 0; max_wait = 0;
    m_addr = '0; m_wr = 1'b0; m_wdata = '0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      ireq = bus.i_pmem_read;
      dreq = bus.d_pmem_read | bus.d_pmem_write;
      if (m_busy) begin
        if (bus.pmem_resp) begin m_busy = 0; m_last = m_owner; end
      end else if (ireq && !(dreq && m_last == 1)) begin
        m_busy = 1; m_owner = 1; m_addr = bus.i_pmem_address; m_wr = 1'b0;
      end else if (dreq) begin
        m_busy = 1; m_owner = 2; m_addr = bus.d_pmem_address;
        m_wr = bus.d_pmem_write; m_wdata = bus.d_pmem_wdata;
      end
      #1;
      if (i_done) begin bus.i_pmem_read = 1'b0; i_done = 0; end
      else if (!bus.i_pmem_read && $urandom_range(0, 3) == 0) bus.i_pmem_read = 1'b1;
      if (bus.i_pmem_read) bus.i_pmem_address = AW'($urandom);
      if (d_done) begin bus.d_pmem_read = 1'b0; bus.d_pmem_write = 1'b0; d_done = 0; end
      else if (!(bus.d_pmem_read | bus.d_pmem_write) && $urandom_range(0, 3) == 0) begin
        op = int'($urandom_range(0, 2));
        bus.d_pmem_read  = (op != 1);
        bus.d_pmem_write = (op != 0);
      end
      if (bus.d_pmem_read | bus.d_pmem_write) begin
        bus.d_pmem_address = AW'($urandom);
        bus.d_pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
      end
      bus.pmem_resp = 1'b0;
      if (bus.pmem_read | bus.pmem_write) begin
        if (mem_cnt < 0) mem_cnt = int'($urandom_range(0, 3));
        if (mem_cnt == 0) begin bus.pmem_resp = 1'b1; mem_cnt = -1; end
        else mem_cnt--;
      end else begin
        mem_cnt = -1;
        bus.pmem_resp = ($urandom_range(0, 9) == 0);
      end
      rd_pat = {$urandom, $urandom, $urandom, $urandom};
      bus.pmem_rdata = rd_pat;
      @(negedge clk);
      chk("rnd_pmem_read", LW'(bus.pmem_read), LW'(m_busy && !m_wr));
      chk("rnd_pmem_write", LW'(bus.pmem_write), LW'(m_busy && m_wr));
      if (m_busy) begin
        chk("rnd_pmem_address", LW'(bus.pmem_address), LW'(m_addr));
        if (m_wr) chk("rnd_pmem_wdata", bus.pmem_wdata, m_wdata);
      end
      chk("rnd_i_resp", LW'(bus.i_pmem_resp), LW'(m_busy && m_owner == 1 && bus.pmem_resp));
      chk("rnd_d_resp", LW'(bus.d_pmem_resp), LW'(m_busy && m_owner == 2 && bus.pmem_resp));
      chk("rnd_i_rdata", bus.i_pmem_rdata, rd_pat);
      chk("rnd_d_rdata", bus.d_pmem_rdata, rd_pat);
      if (bus.i_pmem_resp) i_done = 1;
      if (bus.d_pmem_resp) d_done = 1;
      i_wait = (bus.i_pmem_read && !i_done) ? i_wait + 1 : 0;
      d_wait = ((bus.d_pmem_read | bus.d_pmem_write) && !d_done) ? d_wait + 1 : 0;
      if (i_wait > max_wait) max_wait = i_wait;
      if (d_wait > max_wait) max_wait = d_wait;
    end
    chk("rnd_no_starvation", LW'(max_wait <= 30), LW'(1));
  endtask

  initial begin : main
    logic [AW-1:0] fa, sa;
    int gap;
    logic [LW-1:0] tw, pat;

    reset = 1'b1;
    clear_inputs();
    bus.pmem_resp = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_pmem_read", LW'(bus.pmem_read), LW'(0));
    chk("reset_pmem_write", LW'(bus.pmem_write), LW'(0));
    chk("reset_pmem_address", LW'(bus.pmem_address), LW'(0));
    chk("reset_pmem_wdata", bus.pmem_wdata, LW'(0));
    chk("reset_i_resp", LW'(bus.i_pmem_resp), LW'(0));
    chk("reset_d_resp", LW'(bus.d_pmem_resp), LW'(0));
    do_reset();

    // Grant table, applied in order from reset (last grant starts at I).
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h2220, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1110, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h2220, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1110, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h2220, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h1110, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h2220, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    tw = {8{16'hBEEF}};
    for (int k = 0; k < 9; k++) begin
      bus.i_pmem_read    = vecs[k].i_rd;
      bus.d_pmem_read    = vecs[k].d_rd;
      bus.d_pmem_write   = vecs[k].d_wr;
      bus.i_pmem_address = 16'h1110;
      bus.d_pmem_address = 16'h2220;
      bus.d_pmem_wdata   = tw;
      tick();
      bus.i_pmem_read = 1'b0; bus.d_pmem_read = 1'b0; bus.d_pmem_write = 1'b0;
      pat = {4{32'h600D0000 + 32'(k)}};
      bus.pmem_resp  = 1'b1;
      bus.pmem_rdata = pat;
      @(negedge clk);
      chk($sformatf("vec%0d_rd", k), LW'(bus.pmem_read), LW'(vecs[k].exp_rd));
      chk($sformatf("vec%0d_wr", k), LW'(bus.pmem_write), LW'(vecs[k].exp_wr));
      if (vecs[k].exp_rd | vecs[k].exp_wr)
        chk($sformatf("vec%0d_addr", k), LW'(bus.pmem_address), LW'(vecs[k].exp_addr));
      if (vecs[k].exp_wr) chk($sformatf("vec%0d_wdata", k), bus.pmem_wdata, tw);
      chk($sformatf("vec%0d_iresp", k), LW'(bus.i_pmem_resp), LW'(vecs[k].exp_ir));
      chk($sformatf("vec%0d_dresp", k), LW'(bus.d_pmem_resp), LW'(vecs[k].exp_dr));
      chk($sformatf("vec%0d_irdata", k), bus.i_pmem_rdata, pat);
      tick();
      bus.pmem_resp = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_idle_rd", k), LW'(bus.pmem_read), LW'(0));
      chk($sformatf("vec%0d_idle_wr", k), LW'(bus.pmem_write), LW'(0));
    end

    // Contention right after reset goes to D, then I after an idle cycle.
    do_reset();
    contend(fa, sa, gap);
    chk("contend1_first", LW'(fa), LW'(16'h2220));
    chk("contend1_second", LW'(sa), LW'(16'h1110));
    chk("contend1_gap", LW'(gap >= 1), LW'(1));

    // Lone dcache writeback with the requester changing address mid-transfer.
    bus.d_pmem_write   = 1'b1;
    bus.d_pmem_address = 16'h4440;
    bus.d_pmem_wdata   = {8{16'h1234}};
    serve_one("lone_dwb", 16'h4440, 1'b1, {8{16'h1234}}, 2, 1'b0);

    // D was served last, so the next contention goes to I.
    contend(fa, sa, gap);
    chk("contend2_first", LW'(fa), LW'(16'h1110));
    chk("contend2_second", LW'(sa), LW'(16'h2220));
    chk("contend2_gap", LW'(gap >= 1), LW'(1));

    // Lone icache miss with memory responding 3 cycles after the strobe.
    bus.i_pmem_read    = 1'b1;
    bus.i_pmem_address = 16'h1230;
    serve_one("lone_i", 16'h1230, 1'b0, '0, 3, 1'b1);

    // Reset two cycles into an icache transfer.
    do_reset();
    bus.i_pmem_read    = 1'b1;
    bus.i_pmem_address = 16'h3330;
    tick();
    chk("rstmid_pre_rd", LW'(bus.pmem_read), LW'(1));
    tick();
    bus.pmem_resp = 1'b1;
    reset = 1'b1;
    #1;
    chk("rstmid_rd", LW'(bus.pmem_read), LW'(0));
    chk("rstmid_wr", LW'(bus.pmem_write), LW'(0));
    chk("rstmid_iresp", LW'(bus.i_pmem_resp), LW'(0));
    bus.i_pmem_read = 1'b0;
    bus.pmem_resp   = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    bus.d_pmem_read    = 1'b1;
    bus.d_pmem_address = 16'h6660;
    tick();
    @(negedge clk);
    chk("rstmid_new_rd", LW'(bus.pmem_read), LW'(1));
    chk("rstmid_new_addr", LW'(bus.pmem_address), LW'(16'h6660));
    bus.pmem_resp = 1'b1;
    #1;
    chk("rstmid_new_dresp", LW'(bus.d_pmem_resp), LW'(1));
    tick();
    bus.d_pmem_read = 1'b0;
    bus.pmem_resp   = 1'b0;

    do_reset();
    random_phase(3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
